rho_rotate_engine: RTL and testbench
====================================

// Module: rho_rotate_engine
// PURPOSE
//  Sequential Keccak rho step: captures a 1600-bit state, rotates each of the 25 lanes by its rho
//  offset (one lane per clock), then presents the result with a one-cycle write_file strobe and
//  file index to the downstream rotate_write_file stage. Sits between the state loader and the writer.
// PARAMETERS
//  IDX_W    10   width of file_index / completed-state counter (wraps modulo 2**IDX_W)
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     asynchronous, active-low reset
//  start       in   1     request; sampled only in IDLE
//  data_in     in   1600  input state, captured on accepted start
//  busy        out  1     high in ROT and DONE
//  done        out  1     one-cycle pulse, result valid
//  write_file  out  1     same cycle as done; drives writer write_file
//  file_index  out  IDX_W index of the state being written; drives writer file_index
//  data_out    out  1600  rotated state (internal state register)
// BEHAVIOUR
//  Layout: bit (z, lane) at index z*25+lane, z=0..63 slice, lane=x+5*y (0..24); lane L is the 64
//   bits {state[63*25+L], ..., state[0*25+L]}. Rotation: out[z] = in[(z - r) mod 64].
//  Offsets r by lane 0..24: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
//  Reset (rst low, async): state=IDLE, lane counter=0, state reg=0, busy=done=write_file=0,
//   file_index=0. Reset mid-operation aborts; no done is produced for the aborted state.
//  FSM IDLE -> ROT -> DONE -> IDLE:
//   IDLE: start=1 at edge E: state reg <= data_in, lane<=0, go ROT. start=0: hold; data_out holds
//    last result.
//   ROT: each edge rewrites lane `lane` of the state reg with its rotated value, lane<=lane+1;
//    the edge processing lane 24 moves to DONE. Exactly 25 ROT cycles (edges E+1..E+25).
//   DONE: one cycle: done=write_file=1, file_index=current count, data_out final. Next edge: IDLE,
//    counter <= counter+1 (2**IDX_W-1 wraps to 0).
//  Latency: done high in the cycle following edge E+25; next start accepted at earliest in the
//   IDLE cycle after DONE (start in ROT/DONE ignored, not queued).
//  done/write_file/busy are registered-state decodes (glitch-free); data_in may change after E.
//  Lanes never interfere: only the 64 bits of the active lane change per ROT cycle.
// TESTING
//  1 reset: rst=0 mid-ROT at lane 10 -> busy=done=0, data_out=0, file_index=0; next start runs cleanly.
//  2 single bit: data_in bit 1 (lane1,z0) -> data_out only bit 26 set; bit 2 (lane2,z0) -> only bit 1552.
//  3 lane0 identity + patterns: all-zero -> all-zero, all-one -> all-one, lane0-only data unchanged.
//  4 timing: start at edge E -> busy from E, done=write_file=1 only in cycle after E+25, exactly 1 cycle.
//  5 ignore: start held high continuously -> one run per 27 cycles, start during ROT/DONE has no effect.
//  6 index: 1025 back-to-back runs -> file_index 0,1,...,1023,0; compare data_out vs golden rho model.

Source files
------------

// File: rtl/rho_rotate_engine.sv
// Sequential Keccak rho step: rotates one 64-bit lane of the captured 1600-bit state per clock,
// then raises a one-cycle done/write_file strobe with the running file index for the writer.
module rho_rotate_engine #(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1599:0]     data_in,
  output logic              busy,
  output logic              done,
  output logic              write_file,
  output logic [IDX_W-1:0]  file_index,
  output logic [1599:0]     data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [4:0]          r_lane;
  logic [1599:0]       r_data;
  logic [IDX_W-1:0]    r_count;
  logic [5:0]          w_offset;
  logic [63:0]         w_laneIn;
  logic [63:0]         w_laneRot;
  logic [1599:0]       w_rotData;

  function automatic logic [5:0] rhoOffset(input logic [4:0] lane);
    case (lane)
      5'd0:  rhoOffset = 6'd0;
      5'd1:  rhoOffset = 6'd1;
      5'd2:  rhoOffset = 6'd62;
      5'd3:  rhoOffset = 6'd28;
      5'd4:  rhoOffset = 6'd27;
      5'd5:  rhoOffset = 6'd36;
      5'd6:  rhoOffset = 6'd44;
      5'd7:  rhoOffset = 6'd6;
      5'd8:  rhoOffset = 6'd55;
      5'd9:  rhoOffset = 6'd20;
      5'd10: rhoOffset = 6'd3;
      5'd11: rhoOffset = 6'd10;
      5'd12: rhoOffset = 6'd43;
      5'd13: rhoOffset = 6'd25;
      5'd14: rhoOffset = 6'd39;
      5'd15: rhoOffset = 6'd41;
      5'd16: rhoOffset = 6'd45;
      5'd17: rhoOffset = 6'd15;
      5'd18: rhoOffset = 6'd21;
      5'd19: rhoOffset = 6'd8;
      5'd20: rhoOffset = 6'd18;
      5'd21: rhoOffset = 6'd2;
      5'd22: rhoOffset = 6'd61;
      5'd23: rhoOffset = 6'd56;
      5'd24: rhoOffset = 6'd14;
      default: rhoOffset = 6'd0;
    endcase
  endfunction

  // Lane bits are interleaved every 25 positions; gather the active lane, rotate left by
  // its offset, and scatter it back so the other 24 lanes pass through untouched.
  always_comb begin
    w_offset  = rhoOffset(r_lane);
    w_laneIn  = '0;
    for (int z = 0; z < 64; z++) begin
      w_laneIn[z] = r_data[z*25 + int'(r_lane)];
    end
    w_laneRot = (w_laneIn << w_offset) | (w_laneIn >> (7'd64 - {1'b0, w_offset}));
    w_rotData = r_data;
    for (int z = 0; z < 64; z++) begin
      w_rotData[z*25 + int'(r_lane)] = w_laneRot[z];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_ROT;
      S_ROT:   if (r_lane == 5'd24) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // The counter advances only on leaving DONE, so an aborted run never consumes an index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_data <= data_in;
            r_lane <= '0;
          end
        end
        S_ROT: begin
          r_data <= w_rotData;
          r_lane <= r_lane + 5'd1;
        end
        S_DONE: begin
          r_count <= r_count + IDX_W'(1);
        end
        default: begin
          r_lane <= '0;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign write_file = (r_state == S_DONE);
  assign file_index = r_count;
  assign data_out   = r_data;

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Directed bench for rho_rotate_engine: reset/abort, single-bit and pattern vectors, strobe timing,
// start-while-busy behaviour and a full file_index wrap against an independent rho model.
module tb_rho_rotate_engine;

  localparam int IDX_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1599:0]     data_in;
  logic              busy;
  logic              done;
  logic              write_file;
  logic [IDX_W-1:0]  file_index;
  logic [1599:0]     data_out;

  int checkCount;
  int errorCount;
  int expIdx;

  rho_rotate_engine #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .write_file (write_file),
    .file_index (file_index),
    .data_out   (data_out)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rhoOff(input int lane);
    int table_r [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    return table_r[lane];
  endfunction

  // Golden model written bit-by-bit from out[z] = in[(z - r) mod 64].
  function automatic logic [1599:0] rhoModel(input logic [1599:0] s);
    logic [1599:0] res;
    res = '0;
    for (int lane = 0; lane < 25; lane++) begin
      for (int z = 0; z < 64; z++) begin
        res[z*25 + lane] = s[((z - rhoOff(lane) + 64) % 64)*25 + lane];
      end
    end
    return res;
  endfunction

  // Single comparison point; wide values are summarised by their low 64 bits and first bad bit.
  task automatic checkOutput(input string tag, input logic [1599:0] observed,
                             input logic [1599:0] expected);
    int firstBad;
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      firstBad = -1;
      for (int i = 0; i < 1600; i++) begin
        if (firstBad < 0 && observed[i] !== expected[i]) firstBad = i;
      end
      $display("[TB] FAIL %s: observed[63:0]=%h expected[63:0]=%h first differing bit %0d",
               tag, observed[63:0], expected[63:0], firstBad);
    end
  endtask

  // Present data with start for exactly one accepting edge.
  task automatic applyStimulus(input logic [1599:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic waitDone(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [1599:0] d);
    logic seen;
    applyStimulus(d);
    waitDone(seen);
    checkOutput({tag, " done seen"}, 1600'(seen), 1600'(1));
    checkOutput({tag, " data"}, data_out, rhoModel(d));
    checkOutput({tag, " index"}, 1600'(file_index), 1600'(expIdx));
    checkOutput({tag, " write_file"}, 1600'(write_file), 1600'(1));
    expIdx = (expIdx + 1) % (1 << IDX_W);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    expIdx = 0;
  endtask

  initial begin
    logic [1599:0] vec;
    logic [1599:0] expVec;
    logic [1599:0] patA;
    logic [1599:0] patB;
    logic [26:0]   doneMask;
    logic [26:0]   busyMask;
    logic [85:0]   ignoreDone;
    logic [85:0]   ignoreExp;

    checkCount = 0;
    errorCount = 0;
    expIdx     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    data_in    = '0;

    // Reset values while reset is held.
    #12;
    checkOutput("reset busy", 1600'(busy), 1600'(0));
    checkOutput("reset done", 1600'(done), 1600'(0));
    checkOutput("reset write_file", 1600'(write_file), 1600'(0));
    checkOutput("reset index", 1600'(file_index), 1600'(0));
    checkOutput("reset data", data_out, '0);
    @(negedge clk);
    rst = 1'b1;

    // Single-bit vectors with hand-placed expected bits.
    vec = '0; vec[1] = 1'b1;
    expVec = '0; expVec[26] = 1'b1;
    runAndCheck("bit1", vec);
    checkOutput("bit1 hand", data_out, expVec);
    vec = '0; vec[2] = 1'b1;
    expVec = '0; expVec[1552] = 1'b1;
    runAndCheck("bit2", vec);
    checkOutput("bit2 hand", data_out, expVec);

    // Invariant patterns.
    runAndCheck("zeros", '0);
    checkOutput("zeros hand", data_out, '0);
    runAndCheck("ones", '1);
    checkOutput("ones hand", data_out, '1);
    vec = '0;
    for (int z = 0; z < 64; z++) vec[z*25] = z[0] ^ z[3];
    runAndCheck("lane0", vec);
    checkOutput("lane0 hand", data_out, vec);

    // Strobe timing relative to accepting edge E.
    patA = '0;
    for (int i = 0; i < 50; i++) patA[i*32 +: 32] = 32'hA5C3_0000 + 32'(i);
    applyStimulus(patA);
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      doneMask[k] = done;
      busyMask[k] = busy;
      if (k == 25) checkOutput("timing write_file", 1600'(write_file), 1600'(1));
    end
    checkOutput("timing done mask", 1600'(doneMask), 1600'(27'h200_0000));
    checkOutput("timing busy mask", 1600'(busyMask), 1600'(27'h3FF_FFFF));
    checkOutput("timing data", data_out, rhoModel(patA));
    expIdx++;

    // Start held high, data_in changed mid-run: one run per 27 cycles.
    patB = ~patA;
    @(negedge clk);
    data_in = patA;
    start   = 1'b1;
    @(posedge clk);
    ignoreExp = '0;
    ignoreExp[25] = 1'b1;
    ignoreExp[52] = 1'b1;
    ignoreExp[79] = 1'b1;
    for (int k = 0; k < 86; k++) begin
      @(negedge clk);
      ignoreDone[k] = done;
      if (k == 25) checkOutput("ignore first data", data_out, rhoModel(patA));
      if (k == 52) checkOutput("ignore second data", data_out, rhoModel(patB));
      if (k == 2) data_in = patB;
    end
    start = 1'b0;
    checkOutput("ignore done mask", 1600'(ignoreDone), 1600'(ignoreExp));
    pulseReset();

    // Abort mid-run at lane 10 and recover.
    applyStimulus(patA);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort busy", 1600'(busy), 1600'(0));
    checkOutput("abort done", 1600'(done), 1600'(0));
    checkOutput("abort data", data_out, '0);
    checkOutput("abort index", 1600'(file_index), 1600'(0));
    @(negedge clk);
    rst = 1'b1;
    expIdx = 0;
    runAndCheck("after abort", patB);

    // Full index wrap over 1025 runs with pseudo-random states.
    pulseReset();
    for (int r = 0; r < 1025; r++) begin
      for (int i = 0; i < 50; i++) vec[i*32 +: 32] = $urandom;
      runAndCheck("wrap run", vec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
